bus_port_fifo: RTL and testbench

BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

---
 rtl/bus_port_fifo.sv | 178 +++++++++++++++++
 tb/tb_bus_port_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_port_fifo.sv
// Bus port FIFO pair: a TX FIFO (device -> bus arbiter) and an RX FIFO
// (bus arbiter -> device). Both channels are identical show-ahead circular
// buffers with registered occupancy counts and sticky overflow flags.
// Packets pass through untouched; the ID field is never decoded.

module bus_port_fifo_chan #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [width-1:0]           wr_data,
  input  logic                       rd,
  input  logic                       clr_ovf,
  output logic [width-1:0]           rd_data,
  output logic                       pndng,
  output logic                       full,
  output logic                       ovf,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem_r [depth];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             ovf_r;

  logic             rd_ok_s;
  logic             wr_ok_s;
  logic             ovf_set_s;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_nxt_s;

  // Accept/reject decisions; a read in the same cycle frees a slot for a write to a full FIFO
  always_comb begin
    rd_ok_s   = 1'b0;
    wr_ok_s   = 1'b0;
    ovf_set_s = 1'b0;
    if (rd && (count_r != {CW{1'b0}})) begin
      rd_ok_s = 1'b1;
    end else begin
      rd_ok_s = 1'b0;
    end
    if (wr && ((count_r < CW'(depth)) || rd_ok_s)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    ovf_set_s = wr && !wr_ok_s;
  end

  // Next pointer and count values, pointers wrap from depth-1 back to 0
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (wr_ok_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == PW'(depth - 1)) ? {PW{1'b0}} : (wr_ptr_r + {{(PW-1){1'b0}}, 1'b1});
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_ok_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == PW'(depth - 1)) ? {PW{1'b0}} : (rd_ptr_r + {{(PW-1){1'b0}}, 1'b1});
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and sticky overflow state; set beats clear on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Storage array; not reset, stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Show-ahead head output, forced to zero while the FIFO is empty
  always_comb begin
    rd_data = {width{1'b0}};
    if (count_r != {CW{1'b0}}) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {width{1'b0}};
    end
  end

  assign pndng = (count_r != {CW{1'b0}});
  assign full  = (count_r == CW'(depth));
  assign ovf   = ovf_r;
  assign count = count_r;

endmodule

module bus_port_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dev_push,
  input  logic [width-1:0]           dev_D_in,
  output logic                       dev_full,
  output logic                       pndng,
  input  logic                       pop,
  output logic [width-1:0]           D_pop,
  input  logic                       push,
  input  logic [width-1:0]           D_push,
  output logic                       dev_pndng,
  input  logic                       dev_pop,
  output logic [width-1:0]           dev_D_out,
  input  logic                       clr_ovf,
  output logic                       tx_ovf,
  output logic                       rx_ovf,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic [$clog2(depth+1)-1:0] rx_count
);

  logic rx_full_s;

  bus_port_fifo_chan #(.width(width), .depth(depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr      (dev_push),
    .wr_data (dev_D_in),
    .rd      (pop),
    .clr_ovf (clr_ovf),
    .rd_data (D_pop),
    .pndng   (pndng),
    .full    (dev_full),
    .ovf     (tx_ovf),
    .count   (tx_count)
  );

  bus_port_fifo_chan #(.width(width), .depth(depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr      (push),
    .wr_data (D_push),
    .rd      (dev_pop),
    .clr_ovf (clr_ovf),
    .rd_data (dev_D_out),
    .pndng   (dev_pndng),
    .full    (rx_full_s),
    .ovf     (rx_ovf),
    .count   (rx_count)
  );

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed self-checking bench for bus_port_fifo (width 16, depth 8).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_bus_port_fifo;

  logic        clk;
  logic        reset;
  logic        dev_push;
  logic [15:0] dev_D_in;
  logic        dev_full;
  logic        pndng;
  logic        pop;
  logic [15:0] D_pop;
  logic        push;
  logic [15:0] D_push;
  logic        dev_pndng;
  logic        dev_pop;
  logic [15:0] dev_D_out;
  logic        clr_ovf;
  logic        tx_ovf;
  logic        rx_ovf;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;

  int cmp_cnt;
  int err_cnt;

  bus_port_fifo #(.width(16), .depth(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_push  (dev_push),
    .dev_D_in  (dev_D_in),
    .dev_full  (dev_full),
    .pndng     (pndng),
    .pop       (pop),
    .D_pop     (D_pop),
    .push      (push),
    .D_push    (D_push),
    .dev_pndng (dev_pndng),
    .dev_pop   (dev_pop),
    .dev_D_out (dev_D_out),
    .clr_ovf   (clr_ovf),
    .tx_ovf    (tx_ovf),
    .rx_ovf    (rx_ovf),
    .tx_count  (tx_count),
    .rx_count  (rx_count)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; dev_push = 1'b0; dev_D_in = 16'h0000; pop = 1'b0;
    push = 1'b0; D_push = 16'h0000; dev_pop = 1'b0; clr_ovf = 1'b0;
    step();
    step();
    cmp_cnt++;
    if ({pndng, dev_pndng, dev_full, tx_ovf, rx_ovf} !== 5'b00000) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b want 00000", {pndng, dev_pndng, dev_full, tx_ovf, rx_ovf});
    end
    cmp_cnt++;
    if ({tx_count, rx_count} !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_counts: got tx=%0d rx=%0d want 0 0", tx_count, rx_count);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    dev_push = 1'b1; dev_D_in = 16'h03A5;
    step();
    dev_push = 1'b0;
    cmp_cnt++;
    if (pndng !== 1'b1 || D_pop !== 16'h03A5 || tx_count !== 4'd1) begin
      err_cnt++;
      $display("FAIL single_push: got pndng=%b D_pop=%h cnt=%0d want 1 03a5 1", pndng, D_pop, tx_count);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    cmp_cnt++;
    if (pndng !== 1'b0 || tx_count !== 4'd0) begin
      err_cnt++;
      $display("FAIL single_pop: got pndng=%b cnt=%0d want 0 0", pndng, tx_count);
    end
    // pop on empty must be ignored
    pop = 1'b1;
    step();
    pop = 1'b0;
    cmp_cnt++;
    if (pndng !== 1'b0 || tx_count !== 4'd0 || D_pop !== 16'h0000) begin
      err_cnt++;
      $display("FAIL empty_pop: got pndng=%b cnt=%0d D_pop=%h want 0 0 0000", pndng, tx_count, D_pop);
    end
  endtask

  task automatic test_full_ovf();
    for (int i = 0; i < 8; i++) begin
      dev_push = 1'b1; dev_D_in = 16'h0100 + 16'(i);
      step();
    end
    dev_push = 1'b0;
    cmp_cnt++;
    if (dev_full !== 1'b1 || tx_count !== 4'd8 || tx_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL tx_fill: got full=%b cnt=%0d ovf=%b want 1 8 0", dev_full, tx_count, tx_ovf);
    end
    dev_push = 1'b1; dev_D_in = 16'h0108;
    step();
    dev_push = 1'b0;
    cmp_cnt++;
    if (tx_ovf !== 1'b1 || tx_count !== 4'd8 || D_pop !== 16'h0100) begin
      err_cnt++;
      $display("FAIL tx_overflow: got ovf=%b cnt=%0d head=%h want 1 8 0100", tx_ovf, tx_count, D_pop);
    end
  endtask

  task automatic test_full_push_pop();
    dev_push = 1'b1; dev_D_in = 16'h0F0F; pop = 1'b1;
    step();
    dev_push = 1'b0; pop = 1'b0;
    cmp_cnt++;
    if (D_pop !== 16'h0101 || tx_count !== 4'd8 || tx_ovf !== 1'b1 || dev_full !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_pushpop: got head=%h cnt=%0d ovf=%b full=%b want 0101 8 1 1",
               D_pop, tx_count, tx_ovf, dev_full);
    end
    for (int i = 1; i < 9; i++) begin
      logic [15:0] exp;
      exp = (i == 8) ? 16'h0F0F : (16'h0100 + 16'(i));
      cmp_cnt++;
      if (D_pop !== exp) begin
        err_cnt++;
        $display("FAIL tx_drain[%0d]: got %h want %h", i, D_pop, exp);
      end
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    cmp_cnt++;
    if (pndng !== 1'b0 || tx_count !== 4'd0 || dev_full !== 1'b0) begin
      err_cnt++;
      $display("FAIL tx_drained: got pndng=%b cnt=%0d full=%b want 0 0 0", pndng, tx_count, dev_full);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    cmp_cnt++;
    if (tx_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL tx_clr_ovf: got %b want 0", tx_ovf);
    end
  endtask

  task automatic test_rx_empty_push_pop();
    push = 1'b1; D_push = 16'hFF22; dev_pop = 1'b1;
    step();
    push = 1'b0; dev_pop = 1'b0;
    cmp_cnt++;
    if (rx_count !== 4'd1 || dev_D_out !== 16'hFF22 || dev_pndng !== 1'b1) begin
      err_cnt++;
      $display("FAIL rx_empty_pushpop: got cnt=%0d out=%h pndng=%b want 1 ff22 1",
               rx_count, dev_D_out, dev_pndng);
    end
    dev_pop = 1'b1;
    step();
    dev_pop = 1'b0;
    cmp_cnt++;
    if (rx_count !== 4'd0 || dev_pndng !== 1'b0) begin
      err_cnt++;
      $display("FAIL rx_drain1: got cnt=%0d pndng=%b want 0 0", rx_count, dev_pndng);
    end
  endtask

  task automatic test_wrap();
    push = 1'b1; D_push = 16'h5000;
    step();
    for (int i = 1; i < 20; i++) begin
      cmp_cnt++;
      if (dev_D_out !== (16'h5000 + 16'(i - 1)) || rx_count !== 4'd1) begin
        err_cnt++;
        $display("FAIL rx_wrap[%0d]: got out=%h cnt=%0d want %h 1", i, dev_D_out, rx_count,
                 16'h5000 + 16'(i - 1));
      end
      push = 1'b1; D_push = 16'h5000 + 16'(i); dev_pop = 1'b1;
      step();
    end
    push = 1'b0;
    cmp_cnt++;
    if (dev_D_out !== 16'h5013 || rx_count !== 4'd1) begin
      err_cnt++;
      $display("FAIL rx_wrap_last: got out=%h cnt=%0d want 5013 1", dev_D_out, rx_count);
    end
    step();
    dev_pop = 1'b0;
    cmp_cnt++;
    if (rx_count !== 4'd0 || rx_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL rx_wrap_end: got cnt=%0d ovf=%b want 0 0", rx_count, rx_ovf);
    end
  endtask

  task automatic test_rx_ovf();
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; D_push = 16'h6000 + 16'(i);
      step();
    end
    push = 1'b0;
    cmp_cnt++;
    if (rx_ovf !== 1'b1 || rx_count !== 4'd8 || dev_D_out !== 16'h6000 || tx_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL rx_overflow: got ovf=%b cnt=%0d head=%h txovf=%b want 1 8 6000 0",
               rx_ovf, rx_count, dev_D_out, tx_ovf);
    end
    // set and clear on the same edge: set wins
    push = 1'b1; D_push = 16'h6009; clr_ovf = 1'b1;
    step();
    push = 1'b0;
    cmp_cnt++;
    if (rx_ovf !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_set_wins: got %b want 1", rx_ovf);
    end
    step();
    clr_ovf = 1'b0;
    cmp_cnt++;
    if (rx_ovf !== 1'b0 || rx_count !== 4'd8) begin
      err_cnt++;
      $display("FAIL rx_clr_ovf: got ovf=%b cnt=%0d want 0 8", rx_ovf, rx_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      dev_push = 1'b1; dev_D_in = 16'h0A00 + 16'(i);
      step();
    end
    dev_push = 1'b0;
    cmp_cnt++;
    if (tx_count !== 4'd5 || pndng !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset: got cnt=%0d pndng=%b want 5 1", tx_count, pndng);
    end
    #2;
    reset = 1'b0;
    #1;
    cmp_cnt++;
    if (pndng !== 1'b0 || tx_count !== 4'd0 || dev_pndng !== 1'b0 || rx_count !== 4'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got pndng=%b txc=%0d dev_pndng=%b rxc=%0d want 0 0 0 0",
               pndng, tx_count, dev_pndng, rx_count);
    end
    step();
    reset = 1'b1;
    dev_push = 1'b1; dev_D_in = 16'hBEEF;
    step();
    dev_push = 1'b0;
    cmp_cnt++;
    if (tx_count !== 4'd1 || D_pop !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL post_reset: got cnt=%0d head=%h want 1 beef", tx_count, D_pop);
    end
  endtask

  // Test sequence
  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_single();
    test_full_ovf();
    test_full_push_pop();
    test_rx_empty_push_pop();
    test_wrap();
    test_rx_ovf();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
